uart_param_core: RTL and testbench
==================================

# uart_param_core

Parametrised full-duplex UART core: the successor to the team's fixed-format `uart_run`. It serialises host words onto `txd` and deserialises `rxd` into a receive FIFO. Data width, parity mode, stop-bit count, bit period and RX FIFO depth are all set by parameters. The core adds a TX ready/valid handshake, mid-bit RX sampling with false-start rejection, and sticky parity, framing and overrun flags. It sits between the host-side register/bus logic and the board serial pins.

## Interface
- CLK_DIV, 16: `clk` cycles per serial bit; legal range ≥ 4.
- DATA_BITS, 8: payload width; legal range 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 8: RX FIFO entries; must be a power of 2, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- d_in  in  DATA_BITS  TX word.
- write  in  1  TX request; a word is accepted when `write & tx_ready`.
- tx_ready  out  1  transmitter idle, able to accept a word.
- txd  out  1  serial output; idle high.
- rxd  in  1  serial input; asynchronous.
- d_out  out  DATA_BITS  RX FIFO head (show-ahead); 0 when the FIFO is empty.
- get  out  1  RX FIFO non-empty.
- read  in  1  pop the FIFO head; ignored when empty.
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- perr, ferr, ovr  out  1 each  sticky parity, framing and overrun flags.
- err_clr  in  1  clears all three flags.

## Operation
- Reset values: txd=1, tx_ready=1, get=0, d_out=0, rx_count=0, perr=ferr=ovr=0. Both FSMs go to IDLE, counters clear, FIFO pointers clear.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
  - On accept, `d_in` is latched and the parity bit is computed from the latched word.
  - Odd parity: the total count of ones (data + parity) is odd. Even parity: the total is even.
  - Data is sent LSB first; every bit lasts exactly CLK_DIV cycles.
  - STOP lasts STOP_BITS × CLK_DIV cycles.
- RX path:
  - `rxd` passes through a 2-flop synchroniser reset to 1.
  - RX FSM states: IDLE → START → DATA → PARITY (optional) → STOP → IDLE.
  - IDLE exits on a synchronised 1→0 edge. START waits CLK_DIV/2 cycles (integer division) and samples.
    - Sample = 1: false start, return to IDLE, nothing pushed.
    - Sample = 0: continue, sampling every CLK_DIV cycles thereafter (mid-bit).
  - Only the first stop bit is sampled. Sample = 0 sets ferr.
  - A parity mismatch sets perr.
  - The word is pushed at the stop-bit sample whether or not errors occurred. The FSM then returns to IDLE immediately, so any extra stop bit is simply seen as idle line.
- FIFO behaviour:
  - Push when full: the word is dropped, ovr is set, contents are unchanged.
  - Push and read in the same cycle when full: both succeed and rx_count is unchanged.
  - Push and read in the same cycle when empty: the push succeeds and the read is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Flags:
  - The flags are sticky.
  - If err_clr coincides with a new error event, the flag stays set (set wins).

## Timing
- TX:
  - Accept at edge N: tx_ready=0 and txd=0 (start bit) from edge N+1.
  - The frame occupies (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles.
  - tx_ready returns to 1 in the cycle after the last stop cycle. A `write` held high in that cycle starts the next frame back-to-back, with no extra idle bit.
  - `write` while tx_ready=0 is ignored; the word is not queued.
- RX:
  - The synchroniser adds 2 cycles.
  - get/d_out/rx_count update on the edge after the stop-bit sample.
  - Pop: d_out shows the next entry on the edge after `read`.
- Asynchronous reset mid-frame: txd=1 immediately, partial RX word discarded, FIFO emptied. After release, the first frame is valid only if its start edge occurs after the release.

## Test plan
- TX format, CLK_DIV=4, DATA_BITS=8, PARITY=2, STOP_BITS=1:
  - Stimulus: write 0x6E.
  - Required: txd sequence 0,0,1,1,1,0,1,1,0,1(parity),1(stop), each bit 4 cycles (44 cycles total).
  - Required: tx_ready low for exactly 44 cycles.
- Loopback (txd→rxd):
  - Stimulus: send 0x6E then 0xA5 back-to-back.
  - Required: rx_count=2; d_out=0x6E, then 0xA5 after one read.
  - Required: perr=ferr=ovr=0.
- False start:
  - Stimulus: drive rxd low for 1 cycle, then high.
  - Required: no push; get=0; RX FSM back in IDLE.
- Error injection:
  - Stimulus: frame 0x55 with the wrong parity bit. Required: word pushed, perr=1.
  - Stimulus: frame with stop bit = 0. Required: ferr=1.
  - Stimulus: err_clr. Required: all flags 0.
- Overrun, FIFO_DEPTH=4:
  - Stimulus: 5 frames (0x01..0x05) with no read.
  - Required: rx_count=4, ovr=1, d_out=0x01.
  - Stimulus: then read while a 6th frame (0x06) completes. Required: rx_count stays 4.
- Reset mid-frame:
  - Stimulus: assert clrn low during TX data bit 3 and RX data bit 3.
  - Required: txd=1, tx_ready=1, rx_count=0 immediately.
  - Required: the next full frame after release is received correctly.

Source files
------------

// File: rtl/uart_param_core.sv
// uart_param_core: parametrised full-duplex UART with show-ahead RX FIFO and sticky error flags.
module uart_param_core #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic [DATA_BITS-1:0]          d_in,
  input  logic                          write,
  output logic                          tx_ready,
  output logic                          txd,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          d_out,
  output logic                          get,
  input  logic                          read,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          perr,
  output logic                          ferr,
  output logic                          ovr,
  input  logic                          err_clr
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = 4;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam bit          PAR_ODD = (PARITY == 1);
  localparam bit          HAS_PAR = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t               tx_state, tx_state_nxt;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_nxt;
  logic [BIT_W-1:0]     tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_shr, tx_shr_nxt;
  logic                 tx_par, tx_par_nxt;
  logic                 txd_nxt, tx_ready_nxt;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt == CNT_W'(CLK_DIV - 1));

  // TX state register; line outputs are registered from the state being entered
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shr   <= '0;
      tx_par   <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shr   <= tx_shr_nxt;
      tx_par   <= tx_par_nxt;
      txd      <= txd_nxt;
      tx_ready <= tx_ready_nxt;
    end
  end

  // TX next state: bit timing, shift register and bit index
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shr_nxt   = tx_shr;
    tx_par_nxt   = tx_par;
    if (tx_state != S_IDLE) tx_cnt_nxt = tx_tick ? '0 : tx_cnt + CNT_W'(1);
    unique case (tx_state)
      S_IDLE: if (write) begin
        tx_state_nxt = S_START;
        tx_cnt_nxt   = '0;
        tx_bit_nxt   = '0;
        tx_shr_nxt   = d_in;
        tx_par_nxt   = (^d_in) ^ PAR_ODD;
      end
      S_START: if (tx_tick) begin
        tx_state_nxt = S_DATA;
        tx_bit_nxt   = '0;
      end
      S_DATA: if (tx_tick) begin
        tx_shr_nxt = tx_shr >> 1;
        if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
          tx_state_nxt = HAS_PAR ? S_PAR : S_STOP;
          tx_bit_nxt   = '0;
        end else begin
          tx_bit_nxt = tx_bit + BIT_W'(1);
        end
      end
      S_PAR: if (tx_tick) begin
        tx_state_nxt = S_STOP;
        tx_bit_nxt   = '0;
      end
      S_STOP: if (tx_tick) begin
        if (tx_bit == BIT_W'(STOP_BITS - 1)) tx_state_nxt = S_IDLE;
        else                                 tx_bit_nxt   = tx_bit + BIT_W'(1);
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  // TX outputs for the upcoming cycle
  always_comb begin
    txd_nxt      = 1'b1;
    tx_ready_nxt = (tx_state_nxt == S_IDLE);
    unique case (tx_state_nxt)
      S_START: txd_nxt = 1'b0;
      S_DATA:  txd_nxt = tx_shr_nxt[0];
      S_PAR:   txd_nxt = tx_par_nxt;
      default: txd_nxt = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  state_t               rx_state, rx_state_nxt;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shr;
  logic                 rx_par_bad;
  logic                 s1, s2, s3;
  logic                 rx_fall, rx_sample;
  logic                 rx_push_c, perr_set_c, ferr_set_c;

  // rxd synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rx_fall   = s3 & ~s2;
  assign rx_sample = (rx_state == S_START) ? (rx_cnt == CNT_W'(HALF - 1))
                   : ((rx_state != S_IDLE) && (rx_cnt == CNT_W'(CLK_DIV - 1)));

  // RX state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) rx_state <= S_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  // RX next state: start qualification at half bit, then one sample per bit
  always_comb begin
    rx_state_nxt = rx_state;
    unique case (rx_state)
      S_IDLE:  if (rx_fall) rx_state_nxt = S_START;
      S_START: if (rx_sample) rx_state_nxt = s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_sample && (rx_bit == BIT_W'(DATA_BITS - 1)))
                 rx_state_nxt = HAS_PAR ? S_PAR : S_STOP;
      S_PAR:   if (rx_sample) rx_state_nxt = S_STOP;
      S_STOP:  if (rx_sample) rx_state_nxt = S_IDLE;
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  // RX outputs: push strobe and error events at the stop-bit sample
  always_comb begin
    rx_push_c  = (rx_state == S_STOP) && rx_sample;
    ferr_set_c = rx_push_c && !s2;
    perr_set_c = rx_push_c && rx_par_bad;
  end

  // RX datapath: bit counter, bit index, shift-in and parity check
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shr     <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_cnt <= (rx_state == S_IDLE || rx_sample) ? '0 : rx_cnt + CNT_W'(1);
      if (rx_state != S_DATA) rx_bit <= '0;
      else if (rx_sample)     rx_bit <= rx_bit + BIT_W'(1);
      if (rx_state == S_DATA && rx_sample) rx_shr <= {s2, rx_shr[DATA_BITS-1:1]};
      if (rx_state == S_START) rx_par_bad <= 1'b0;
      else if (rx_state == S_PAR && rx_sample) rx_par_bad <= (s2 != ((^rx_shr) ^ PAR_ODD));
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [OCC_W-1:0]     count_nxt;
  logic [DATA_BITS-1:0] head_nxt;
  logic                 full_c, do_push_c, do_pop_c, ovr_set_c;

  // FIFO control and next show-ahead head value
  always_comb begin
    full_c     = (rx_count == OCC_W'(FIFO_DEPTH));
    do_pop_c   = read && (rx_count != '0);
    do_push_c  = rx_push_c && (!full_c || read);
    ovr_set_c  = rx_push_c && full_c && !read;
    rd_ptr_nxt = rd_ptr + PTR_W'(do_pop_c);
    count_nxt  = rx_count + OCC_W'(do_push_c) - OCC_W'(do_pop_c);
    if (count_nxt == '0)
      head_nxt = '0;
    else if (do_push_c && (rx_count == '0 || (rx_count == OCC_W'(1) && do_pop_c)))
      head_nxt = rx_shr;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= rx_shr;
  end

  // FIFO pointers, occupancy and registered head
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      get      <= 1'b0;
      d_out    <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr   <= rd_ptr_nxt;
      rx_count <= count_nxt;
      get      <= (count_nxt != '0);
      d_out    <= head_nxt;
    end
  end

  // Sticky error flags; a new event wins over err_clr
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      perr <= 1'b0;
      ferr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      perr <= perr_set_c | (perr & ~err_clr);
      ferr <= ferr_set_c | (ferr & ~err_clr);
      ovr  <= ovr_set_c  | (ovr  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: queue-based reference model of the RX FIFO, a popping monitor,
// directed TX waveform check and randomized loopback traffic.
module tb_uart_param_core;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned PARITY     = 2;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned NBITS      = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int unsigned FRAME      = NBITS * CLK_DIV;

  logic                 clk = 1'b0;
  logic                 clrn, write, rxd, read, err_clr;
  logic [DATA_BITS-1:0] d_in, d_out;
  logic                 tx_ready, txd, get, perr, ferr, ovr;
  logic [OCC_W-1:0]     rx_count;

  logic                 loop, bfm_line, rd_en, mon_read, tst_read;
  logic                 exp_perr, exp_ferr, exp_ovr;
  logic [7:0]           rxm [$];
  int                   checks = 0;
  int                   failures = 0;

  uart_param_core #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY(PARITY),
    .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .clrn(clrn), .d_in(d_in), .write(write), .tx_ready(tx_ready), .txd(txd),
    .rxd(rxd), .d_out(d_out), .get(get), .read(read), .rx_count(rx_count),
    .perr(perr), .ferr(ferr), .ovr(ovr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  assign rxd  = loop ? txd : bfm_line;
  assign read = mon_read | tst_read;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Parity bit from the rule "total ones odd (odd mode) / even (even mode)"
  function automatic logic ref_par(input logic [7:0] d);
    int ones;
    ones = $countones(d);
    if (PARITY == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  // Whole serial frame, bit 0 sent first
  function automatic logic [NBITS-1:0] ref_frame(input logic [7:0] d, input logic flip, input logic zero_stop);
    return {~zero_stop, ref_par(d) ^ flip, d, 1'b0};
  endfunction

  // Reference FIFO: a push into a full FIFO is dropped and raises overrun
  task automatic model_push(input logic [7:0] d);
    if (rxm.size() == FIFO_DEPTH) exp_ovr = 1'b1;
    else rxm.push_back(d);
  endtask

  task automatic bfm_frame(input logic [7:0] d, input logic flip, input logic zero_stop);
    logic [NBITS-1:0] f;
    f = ref_frame(d, flip, zero_stop);
    for (int i = 0; i < NBITS; i++) begin
      bfm_line = f[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    bfm_line = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
  endtask

  task automatic wait_tx_idle();
    int t = 0;
    while (!tx_ready && t < 4 * FRAME) begin @(negedge clk); t++; end
    if (!tx_ready) check("tx_idle_timeout", 32'(tx_ready), 32'(1));
    repeat (4 * CLK_DIV) @(negedge clk);
  endtask

  task automatic tx_word(input logic [7:0] d, input logic junk);
    int t = 0;
    while (!tx_ready && t < 4 * FRAME) begin @(negedge clk); t++; end
    if (!tx_ready) check("tx_ready_timeout", 32'(tx_ready), 32'(1));
    d_in = d; write = 1'b1;
    if (loop) model_push(d);
    @(negedge clk); write = 1'b0;
    if (junk) begin
      repeat (5) @(negedge clk);
      d_in = ~d; write = 1'b1;
      @(negedge clk); write = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (rxm.size() != 0 && t < 10 * FRAME) begin @(negedge clk); t++; end
    if (rxm.size() != 0) check("drain_timeout", 32'(rxm.size()), 32'(0));
    repeat (2) @(negedge clk);
    check("drained_get", 32'(get), 32'(0));
    check("drained_count", 32'(rx_count), 32'(0));
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_perr"}, 32'(perr), 32'(exp_perr));
    check({tag, "_ferr"}, 32'(ferr), 32'(exp_ferr));
    check({tag, "_ovr"},  32'(ovr),  32'(exp_ovr));
  endtask

  // Monitor: pops and compares the FIFO head whenever reading is enabled and data is present
  always @(negedge clk) begin
    mon_read = 1'b0;
    if (rd_en && get && clrn) begin
      if (rxm.size() == 0) begin
        check("rx_unexpected_word", 32'(d_out), 32'hFFFF_FFFF);
      end else begin
        check("rx_data", 32'(d_out), 32'(rxm.pop_front()));
        mon_read = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [OCC_W-1:0] c0;
    logic [NBITS-1:0] f;
    logic [7:0] d;

    clrn = 1'b0; write = 1'b0; d_in = '0; err_clr = 1'b0; bfm_line = 1'b1;
    loop = 1'b0; rd_en = 1'b0; mon_read = 1'b0; tst_read = 1'b0;
    exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'(1));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_get", 32'(get), 32'(0));
    check("rst_d_out", 32'(d_out), 32'(0));
    check("rst_rx_count", 32'(rx_count), 32'(0));
    check_flags("rst");
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // TX waveform, cycle by cycle, then back-to-back start
    f = ref_frame(8'h6E, 1'b0, 1'b0);
    d_in = 8'h6E; write = 1'b1;
    @(negedge clk); write = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("tx_cyc%0d", i), 32'({tx_ready, txd}), 32'({1'b0, f[i / CLK_DIV]}));
      @(negedge clk);
    end
    check("tx_ready_after_frame", 32'({tx_ready, txd}), 32'(2'b11));
    d_in = 8'hA5; write = 1'b1;
    @(negedge clk); write = 1'b0;
    check("tx_b2b_start", 32'({tx_ready, txd}), 32'(2'b00));
    wait_tx_idle();

    // Loopback: two words back-to-back, held in FIFO
    loop = 1'b1;
    tx_word(8'h6E, 1'b0);
    tx_word(8'hA5, 1'b0);
    wait_tx_idle();
    check("loop_count", 32'(rx_count), 32'(2));
    check("loop_head", 32'(d_out), 32'(8'h6E));
    check_flags("loop");
    rd_en = 1'b1;
    drain();

    // False start followed by a valid frame
    loop = 1'b0;
    bfm_line = 1'b0; @(negedge clk); bfm_line = 1'b1;
    repeat (4 * CLK_DIV) @(negedge clk);
    check("false_start_get", 32'(get), 32'(0));
    check("false_start_count", 32'(rx_count), 32'(0));
    model_push(8'h3C);
    bfm_frame(8'h3C, 1'b0, 1'b0);
    drain();
    check_flags("after_false_start");

    // Parity error, framing error, clear
    model_push(8'h55); exp_perr = 1'b1;
    bfm_frame(8'h55, 1'b1, 1'b0);
    drain();
    check_flags("perr_inj");
    d = 8'($urandom);
    model_push(d); exp_ferr = 1'b1;
    bfm_frame(d, 1'b0, 1'b1);
    drain();
    check_flags("ferr_inj");
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    @(negedge clk);
    check_flags("err_clr");

    // Overrun: five frames without reading, latency measured on the first
    rd_en = 1'b0;
    model_push(8'h01);
    c0 = rx_count; lat = 0;
    fork
      bfm_frame(8'h01, 1'b0, 1'b0);
      begin
        while (rx_count == c0 && lat < 4 * FRAME) begin @(negedge clk); lat++; end
      end
    join
    check("rx_latency_window", 32'(lat >= int'(FRAME - CLK_DIV) && lat <= int'(FRAME + CLK_DIV)), 32'(1));
    for (int k = 2; k <= 5; k++) begin
      model_push(8'(k));
      bfm_frame(8'(k), 1'b0, 1'b0);
    end
    check("ovr_count", 32'(rx_count), 32'(rxm.size()));
    check("ovr_head", 32'(d_out), 32'(8'h01));
    check_flags("ovr");
    // Sixth frame with a read landing on the push cycle of a full FIFO
    void'(rxm.pop_front());
    rxm.push_back(8'h06);
    fork
      bfm_frame(8'h06, 1'b0, 1'b0);
      begin
        repeat (lat - 1) @(negedge clk);
        tst_read = 1'b1;
        @(negedge clk);
        tst_read = 1'b0;
      end
    join
    check("full_rw_count", 32'(rx_count), 32'(FIFO_DEPTH));
    check("full_rw_head", 32'(d_out), 32'(rxm[0]));
    check_flags("full_rw");
    rd_en = 1'b1;
    drain();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk);
    check_flags("ovr_clr");

    // Reset in the middle of a frame
    rd_en = 1'b0; loop = 1'b1;
    tx_word(8'h11, 1'b0);
    tx_word(8'h22, 1'b0);
    wait_tx_idle();
    check("pre_rst_count", 32'(rx_count), 32'(2));
    d_in = 8'($urandom); write = 1'b1;
    @(negedge clk); write = 1'b0;
    repeat (4 * CLK_DIV + 1) @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 32'(1));
    check("midrst_tx_ready", 32'(tx_ready), 32'(1));
    check("midrst_count", 32'(rx_count), 32'(0));
    check("midrst_get", 32'(get), 32'(0));
    rxm.delete();
    exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    rd_en = 1'b1;
    tx_word(8'($urandom), 1'b0);
    wait_tx_idle();
    drain();
    check_flags("post_rst");

    // Randomized loopback traffic with ignored writes during busy frames
    for (int n = 0; n < 12; n++) begin
      tx_word(8'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_tx_idle();
    drain();
    check_flags("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
